mc_ctrl: RTL and testbench

- Multi-cycle successor to the single-cycle control decoder.
- Sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath strobes per state.
- Adds a memory-ready handshake with a bounded wait and an illegal-instruction flag.
- Sits between the instruction register (Op/Funct) and the multi-cycle datapath: PC, IR, register file, ALU, NPC, unified memory.

---
 rtl/mc_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// ----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS control unit.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes for the current state. Memory accesses in FETCH and MEM
// wait on MemReady, up to a bounded number of not-ready cycles. An access that
// exceeds that bound raises a one-cycle MemFault pulse. An undecodable opcode
// raises a one-cycle IllegalInstr pulse in DECODE.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   Op, Funct      IR[31:26], IR[5:0]; stable from DECODE to the end of the
//                  instruction because IR only loads in FETCH
//   Zero           ALU zero flag (beq)
//   MemReady       memory completes its access this cycle
//   PCWrite/IRWrite/RegWrite/MemRead/MemWrite   datapath strobes
//   IorD           memory address: 0 = PC, 1 = ALUOut
//   EXTOp, ALUOp, ALUSrcA, ALUSrcB              ALU controls
//   NPCOp          00 = PC+4, 01 = branch, 10 = jump
//   GPRSel, WDSel  write-back register / data select
//   State          current state code (FETCH 0 .. WB 4)
//   IllegalInstr   one-cycle pulse on an illegal opcode
//   MemFault       one-cycle pulse on a memory wait timeout
// ----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int ALUOP_W     = 3,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int WAIT_LIMIT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         ALUSrcA,
    output logic               ALUSrcB,
    output logic [1:0]         NPCOp,
    output logic               GPRSel,
    output logic               WDSel,
    output logic [2:0]         State,
    output logic               IllegalInstr,
    output logic               MemFault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;
    localparam logic [2:0] ALU_SLL  = 3'd7;

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // ------------------------------------------------------------------
    // Instruction decode. Purely combinational from IR, which stays put
    // for the whole instruction, so the ALU controls computed here keep
    // their EXEC values through MEM and WB without extra registers.
    // ------------------------------------------------------------------
    logic       dec_legal;
    logic       dec_j;
    logic       dec_beq;
    logic       dec_lw;
    logic       dec_sw;
    logic       dec_rt_dst;
    logic [2:0] dec_alu;
    logic [1:0] dec_src_a;
    logic       dec_src_b;
    logic       dec_ext;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case statements can leave it unassigned and
    // infer a latch.
    always_comb begin
        dec_legal  = 1'b1;
        dec_j      = 1'b0;
        dec_beq    = 1'b0;
        dec_lw     = 1'b0;
        dec_sw     = 1'b0;
        dec_rt_dst = 1'b0;
        dec_alu    = ALU_NOP;
        dec_src_a  = 2'b00;
        dec_src_b  = 1'b0;
        dec_ext    = 1'b0;
        case (Op)
            6'h00: begin
                case (Funct)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h24:        dec_alu = ALU_AND;
                    6'h25:        dec_alu = ALU_OR;
                    6'h2A:        dec_alu = ALU_SLT;
                    6'h2B:        dec_alu = ALU_SLTU;
                    6'h00: begin
                        dec_alu   = ALU_SLL;
                        dec_src_a = 2'b01;
                    end
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08: begin                        // addi
                dec_alu    = ALU_ADD;
                dec_src_b  = 1'b1;
                dec_ext    = 1'b1;
                dec_rt_dst = 1'b1;
            end
            6'h0D: begin                        // ori
                dec_alu    = ALU_OR;
                dec_src_b  = 1'b1;
                dec_rt_dst = 1'b1;
            end
            6'h23: begin                        // lw
                dec_lw     = 1'b1;
                dec_alu    = ALU_ADD;
                dec_src_b  = 1'b1;
                dec_ext    = 1'b1;
                dec_rt_dst = 1'b1;
            end
            6'h2B: begin                        // sw
                dec_sw     = 1'b1;
                dec_alu    = ALU_ADD;
                dec_src_b  = 1'b1;
                dec_ext    = 1'b1;
            end
            6'h04: begin                        // beq
                dec_beq    = 1'b1;
                dec_alu    = ALU_SUB;
            end
            6'h0F: begin                        // lui: (imm << 16) + $zero
                dec_alu    = ALU_ADD;
                dec_src_a  = 2'b10;
                dec_rt_dst = 1'b1;
            end
            6'h02:   dec_j     = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state, wait counter and strobes.
    // ------------------------------------------------------------------
    logic       ready;
    logic       timeout;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d;
    logic       ext_op, src_b, gpr_sel, wd_sel, illegal, fault;
    logic [2:0] alu_op;
    logic [1:0] src_a, npc_op;

    // With MEM_WAIT_EN = 0 ready is constant 1, so the counter never moves
    // and timeout can never fire.
    assign ready   = MEM_WAIT_EN ? MemReady : 1'b1;
    assign timeout = !ready && (wait_cnt_q == WAIT_LIMIT_C);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;      // clears on ready and on every state change
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ext_op     = 1'b0;
        alu_op     = ALU_NOP;
        src_a      = 2'b00;
        src_b      = 1'b0;
        npc_op     = 2'b00;
        gpr_sel    = 1'b0;
        wd_sel     = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;

        // ALU controls are driven from EXEC until the instruction retires.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_op = dec_alu;
            src_a  = dec_src_a;
            src_b  = dec_src_b;
            ext_op = dec_ext;
        end

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    fault    = 1'b1;            // retry the fetch
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (dec_j) begin
                    pc_write = 1'b1;
                    npc_op   = 2'b10;
                    state_d  = S_FETCH;
                end else if (!dec_legal) begin
                    illegal  = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_beq) begin
                    pc_write = Zero;
                    npc_op   = 2'b01;
                    state_d  = S_FETCH;
                end else if (dec_lw || dec_sw) begin
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = dec_lw;
                mem_write = dec_sw;
                if (ready) begin
                    state_d = dec_lw ? S_WB : S_FETCH;
                end else if (timeout) begin
                    fault   = 1'b1;             // abandon: no write-back
                    state_d = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                gpr_sel   = dec_rt_dst;
                wd_sel    = dec_lw;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are forced low combinationally while rst is high, so a
    // reset arriving mid-instruction cuts any write strobe immediately.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite      = pc_write  && !rst;
        IRWrite      = ir_write  && !rst;
        RegWrite     = reg_write && !rst;
        MemRead      = mem_read  && !rst;
        MemWrite     = mem_write && !rst;
        IorD         = i_or_d    && !rst;
        EXTOp        = ext_op    && !rst;
        ALUSrcB      = src_b     && !rst;
        GPRSel       = gpr_sel   && !rst;
        WDSel        = wd_sel    && !rst;
        IllegalInstr = illegal   && !rst;
        MemFault     = fault     && !rst;
        ALUOp        = rst ? '0 : ALUOP_W'(alu_op);
        ALUSrcA      = rst ? 2'b00 : src_a;
        NPCOp        = rst ? 2'b00 : npc_op;
        State        = rst ? 3'd0 : state_q;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl (default parameters).
//
// Every cycle's outputs are packed into one 22-bit word
//   {State, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
//    ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel, IllegalInstr, MemFault}
// and compared against a hand-built expectation. Inputs change at the
// falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp;
    logic [2:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic       ALUSrcB;
    logic [1:0] NPCOp;
    logic       GPRSel, WDSel;
    logic [2:0] State;
    logic       IllegalInstr, MemFault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.ALUOP_W(3), .MEM_WAIT_EN(1'b1), .WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
        .State(State), .IllegalInstr(IllegalInstr), .MemFault(MemFault)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] ev(
        input logic [2:0] st, input logic pcw, irw, rw, mr, mw, iord, ext,
        input logic [2:0] alu, input logic [1:0] sa, input logic sb,
        input logic [1:0] npc, input logic gpr, wd, ill, flt);
        return {st, pcw, irw, rw, mr, mw, iord, ext, alu, sa, sb, npc,
                gpr, wd, ill, flt};
    endfunction

    function automatic logic [21:0] actual();
        return {State, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD,
                EXTOp, ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel,
                IllegalInstr, MemFault};
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, funct,
                           input logic zero, rdy, input logic [21:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct;
        v.zero = zero; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive at the falling edge, check shortly after.
    task automatic step(input string name, input logic [5:0] op, funct,
                        input logic zero, rdy, input logic [21:0] exp);
        @(negedge clk);
        Op = op; Funct = funct; Zero = zero; MemReady = rdy;
        #1;
        check(name, exp);
    endtask

    logic [21:0] zero_v, f_go, f_wait, dec, f_flt;
    logic [21:0] lw_ex, lw_mem, lw_mem_flt, lw_wb, sw_mem;

    initial begin
        zero_v     = '0;
        f_go       = ev(3'd0, 1,1,0,1,0,0,0, 3'd0, 2'd0, 0, 2'd0, 0,0,0,0);
        f_wait     = ev(3'd0, 0,0,0,1,0,0,0, 3'd0, 2'd0, 0, 2'd0, 0,0,0,0);
        f_flt      = ev(3'd0, 0,0,0,1,0,0,0, 3'd0, 2'd0, 0, 2'd0, 0,0,0,1);
        dec        = ev(3'd1, 0,0,0,0,0,0,0, 3'd0, 2'd0, 0, 2'd0, 0,0,0,0);
        lw_ex      = ev(3'd2, 0,0,0,0,0,0,1, 3'd1, 2'd0, 1, 2'd0, 0,0,0,0);
        lw_mem     = ev(3'd3, 0,0,0,1,0,1,1, 3'd1, 2'd0, 1, 2'd0, 0,0,0,0);
        lw_mem_flt = ev(3'd3, 0,0,0,1,0,1,1, 3'd1, 2'd0, 1, 2'd0, 0,0,0,1);
        lw_wb      = ev(3'd4, 0,0,1,0,0,0,1, 3'd1, 2'd0, 1, 2'd0, 1,1,0,0);
        sw_mem     = ev(3'd3, 0,0,0,0,1,1,1, 3'd1, 2'd0, 1, 2'd0, 0,0,0,0);

        // add: 4 cycles
        add_vec("add_fetch",  6'h00, 6'h20, 0, 1, f_go);
        add_vec("add_decode", 6'h00, 6'h20, 0, 1, dec);
        add_vec("add_exec",   6'h00, 6'h20, 0, 1, ev(3'd2, 0,0,0,0,0,0,0, 3'd1, 2'd0, 0, 2'd0, 0,0,0,0));
        add_vec("add_wb",     6'h00, 6'h20, 0, 1, ev(3'd4, 0,0,1,0,0,0,0, 3'd1, 2'd0, 0, 2'd0, 0,0,0,0));
        // lw with three not-ready MEM cycles
        add_vec("lw_fetch",   6'h23, 6'h00, 0, 1, f_go);
        add_vec("lw_decode",  6'h23, 6'h00, 0, 1, dec);
        add_vec("lw_exec",    6'h23, 6'h00, 0, 1, lw_ex);
        add_vec("lw_mem_w0",  6'h23, 6'h00, 0, 0, lw_mem);
        add_vec("lw_mem_w1",  6'h23, 6'h00, 0, 0, lw_mem);
        add_vec("lw_mem_w2",  6'h23, 6'h00, 0, 0, lw_mem);
        add_vec("lw_mem_rdy", 6'h23, 6'h00, 0, 1, lw_mem);
        add_vec("lw_wb",      6'h23, 6'h00, 0, 1, lw_wb);
        // beq taken / not taken: 3 cycles each
        add_vec("beq1_fetch", 6'h04, 6'h00, 1, 1, f_go);
        add_vec("beq1_dec",   6'h04, 6'h00, 1, 1, dec);
        add_vec("beq1_exec",  6'h04, 6'h00, 1, 1, ev(3'd2, 1,0,0,0,0,0,0, 3'd2, 2'd0, 0, 2'd1, 0,0,0,0));
        add_vec("beq0_fetch", 6'h04, 6'h00, 0, 1, f_go);
        add_vec("beq0_dec",   6'h04, 6'h00, 0, 1, dec);
        add_vec("beq0_exec",  6'h04, 6'h00, 0, 1, ev(3'd2, 0,0,0,0,0,0,0, 3'd2, 2'd1, 0, 2'd1, 0,0,0,0) >> 0 & ~22'h0 & ev(3'd2, 0,0,0,0,0,0,0, 3'd2, 2'd0, 0, 2'd1, 0,0,0,0));
        // sw, one fetch wait first
        add_vec("sw_fwait",   6'h2B, 6'h00, 0, 0, f_wait);
        add_vec("sw_fetch",   6'h2B, 6'h00, 0, 1, f_go);
        add_vec("sw_decode",  6'h2B, 6'h00, 0, 1, dec);
        add_vec("sw_exec",    6'h2B, 6'h00, 0, 1, lw_ex);
        add_vec("sw_mem",     6'h2B, 6'h00, 0, 1, sw_mem);
        // illegal opcode, then sll
        add_vec("ill_fetch",  6'h3F, 6'h00, 0, 1, f_go);
        add_vec("ill_decode", 6'h3F, 6'h00, 0, 1, ev(3'd1, 0,0,0,0,0,0,0, 3'd0, 2'd0, 0, 2'd0, 0,0,1,0));
        add_vec("sll_fetch",  6'h00, 6'h00, 0, 1, f_go);
        add_vec("sll_decode", 6'h00, 6'h00, 0, 1, dec);
        add_vec("sll_exec",   6'h00, 6'h00, 0, 1, ev(3'd2, 0,0,0,0,0,0,0, 3'd7, 2'd1, 0, 2'd0, 0,0,0,0));
        add_vec("sll_wb",     6'h00, 6'h00, 0, 1, ev(3'd4, 0,0,1,0,0,0,0, 3'd7, 2'd1, 0, 2'd0, 0,0,0,0));
        // j: 2 cycles
        add_vec("j_fetch",    6'h02, 6'h00, 0, 1, f_go);
        add_vec("j_decode",   6'h02, 6'h00, 0, 1, ev(3'd1, 1,0,0,0,0,0,0, 3'd0, 2'd0, 0, 2'd2, 0,0,0,0));
        // sltu (R-type, unsigned compare)
        add_vec("sltu_fetch", 6'h00, 6'h2B, 0, 1, f_go);
        add_vec("sltu_dec",   6'h00, 6'h2B, 0, 1, dec);
        add_vec("sltu_exec",  6'h00, 6'h2B, 0, 1, ev(3'd2, 0,0,0,0,0,0,0, 3'd6, 2'd0, 0, 2'd0, 0,0,0,0));
        add_vec("sltu_wb",    6'h00, 6'h2B, 0, 1, ev(3'd4, 0,0,1,0,0,0,0, 3'd6, 2'd0, 0, 2'd0, 0,0,0,0));
        // ori: zero-extended immediate, rt destination
        add_vec("ori_fetch",  6'h0D, 6'h00, 0, 1, f_go);
        add_vec("ori_decode", 6'h0D, 6'h00, 0, 1, dec);
        add_vec("ori_exec",   6'h0D, 6'h00, 0, 1, ev(3'd2, 0,0,0,0,0,0,0, 3'd4, 2'd0, 1, 2'd0, 0,0,0,0));
        add_vec("ori_wb",     6'h0D, 6'h00, 0, 1, ev(3'd4, 0,0,1,0,0,0,0, 3'd4, 2'd0, 1, 2'd0, 1,0,0,0));

        // ---------------- reset, including reset mid-EXEC ----------------
        rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", zero_v);
        @(negedge clk);
        rst = 1'b0; MemReady = 1'b0;
        #1 check("release_fetch", f_wait);
        step("rst_add_fetch",  6'h00, 6'h20, 0, 1, f_go);
        step("rst_add_decode", 6'h00, 6'h20, 0, 1, dec);
        step("rst_add_exec",   6'h00, 6'h20, 0, 1, ev(3'd2, 0,0,0,0,0,0,0, 3'd1, 2'd0, 0, 2'd0, 0,0,0,0));
        #2 rst = 1'b1;
        #1 check("rst_mid_exec", zero_v);
        @(negedge clk);
        #1 check("rst_held", zero_v);
        @(negedge clk);
        rst = 1'b0; MemReady = 1'b0;
        #1 check("rst_release_fetch", f_wait);

        // ---------------- table-driven instruction sequences -------------
        foreach (vecs[i])
            step(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero,
                 vecs[i].rdy, vecs[i].exp);

        // ---------------- FETCH stuck not-ready: fault every 16th cycle --
        for (int i = 0; i < 40; i++)
            step("fetch_stuck", 6'h23, 6'h00, 0, 0, (i % 16 == 15) ? f_flt : f_wait);

        // ---------------- lw MEM timeout: abandon without write-back -----
        step("to_lw_fetch",  6'h23, 6'h00, 0, 1, f_go);
        step("to_lw_decode", 6'h23, 6'h00, 0, 1, dec);
        step("to_lw_exec",   6'h23, 6'h00, 0, 1, lw_ex);
        for (int i = 0; i < 16; i++)
            step("to_lw_mem", 6'h23, 6'h00, 0, 0, (i == 15) ? lw_mem_flt : lw_mem);
        step("to_lw_back_fetch", 6'h23, 6'h00, 0, 0, f_wait);

        // ---------------- sw: MemReady in the limit cycle wins -----------
        step("rw_sw_fetch",  6'h2B, 6'h00, 0, 1, f_go);
        step("rw_sw_decode", 6'h2B, 6'h00, 0, 1, dec);
        step("rw_sw_exec",   6'h2B, 6'h00, 0, 1, lw_ex);
        for (int i = 0; i < 15; i++)
            step("rw_sw_mem_wait", 6'h2B, 6'h00, 0, 0, sw_mem);
        step("rw_sw_mem_ready", 6'h2B, 6'h00, 0, 1, sw_mem);
        step("rw_sw_back_fetch", 6'h00, 6'h20, 0, 1, f_go);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
